// File: rtl/intl_ext_monitor.sv
// N-channel external interlock monitor: per-channel sync/polarity/debounce, bypass-masked
// latched fault vector with edge-triggered clear, and a frozen first-fault record.

module intl_ext_monitor_ch #(
  parameter int DEB_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ext,
  input  logic                 i_pol,
  input  logic [DEB_WIDTH-1:0] i_deb_count,
  output logic                 o_raw
);
  logic [1:0]           sync;
  logic [DEB_WIDTH-1:0] cnt;
  logic                 fault;

  assign fault = ~(sync[1] ^ i_pol);

  // Assertion is debounced; deassertion drops raw immediately.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync  <= '0;
      cnt   <= '0;
      o_raw <= 1'b0;
    end else begin
      sync <= {sync[0], i_ext};
      if (!fault) begin
        cnt   <= '0;
        o_raw <= 1'b0;
      end else if (cnt < i_deb_count) begin
        cnt <= cnt + DEB_WIDTH'(1);
      end else begin
        o_raw <= 1'b1;
      end
    end
  end
endmodule

module intl_ext_monitor #(
  parameter int CH_NUM    = 16,
  parameter int DEB_WIDTH = 16,
  parameter int TS_WIDTH  = 32,
  parameter int CH_IDX_W  = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [CH_NUM-1:0]    i_intl_ext,
  input  logic [CH_NUM-1:0]    i_intl_polarity,
  input  logic [CH_NUM-1:0]    i_intl_bypass,
  input  logic [DEB_WIDTH-1:0] i_deb_count,
  input  logic                 i_intl_clr,
  output logic [CH_NUM-1:0]    o_intl_raw,
  output logic [CH_NUM-1:0]    o_intl_state,
  output logic                 o_intl_any,
  output logic                 o_first_fault_valid,
  output logic [CH_IDX_W-1:0]  o_first_fault_ch,
  output logic [TS_WIDTH-1:0]  o_first_fault_ts
);
  typedef enum logic {IDLE = 1'b0, CAPTURED = 1'b1} ff_state_t;

  ff_state_t             ff_q, ff_d;
  logic [CH_NUM-1:0]     raw, mask, latch_d, newset;
  logic                  clr_q, clr_edge;
  logic [CH_IDX_W-1:0]   low_idx, ch_d;
  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  logic                  valid_d;

  generate
    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
      intl_ext_monitor_ch #(.DEB_WIDTH(DEB_WIDTH)) u_ch (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_ext       (i_intl_ext[g]),
        .i_pol       (i_intl_polarity[g]),
        .i_deb_count (i_deb_count),
        .o_raw       (raw[g])
      );
    end
  endgenerate

  assign o_intl_raw = raw;
  assign clr_edge   = i_intl_clr & ~clr_q;
  assign mask       = raw & ~i_intl_bypass;
  // Clear reloads from the live masked faults, so set wins over clear.
  assign latch_d    = clr_edge ? mask : (o_intl_state | mask);
  assign newset     = latch_d & ~o_intl_state;

  always_comb begin
    low_idx = '0;
    for (int i = CH_NUM - 1; i >= 0; i--)
      if (newset[i]) low_idx = CH_IDX_W'(i);
  end

  always_comb begin
    ff_d    = ff_q;
    valid_d = o_first_fault_valid;
    ch_d    = o_first_fault_ch;
    ts_d    = o_first_fault_ts;
    case (ff_q)
      IDLE: if (|newset) begin
        ff_d    = CAPTURED;
        valid_d = 1'b1;
        ch_d    = low_idx;
        ts_d    = ts_q;
      end
      CAPTURED: if (clr_edge && !(|latch_d)) begin
        ff_d    = IDLE;
        valid_d = 1'b0;
        ch_d    = '0;
        ts_d    = '0;
      end
      default: ff_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ff_q                <= IDLE;
      clr_q               <= 1'b0;
      ts_q                <= '0;
      o_intl_state        <= '0;
      o_intl_any          <= 1'b0;
      o_first_fault_valid <= 1'b0;
      o_first_fault_ch    <= '0;
      o_first_fault_ts    <= '0;
    end else begin
      ff_q                <= ff_d;
      clr_q               <= i_intl_clr;
      ts_q                <= ts_q + TS_WIDTH'(1);
      o_intl_state        <= latch_d;
      o_intl_any          <= |latch_d;
      o_first_fault_valid <= valid_d;
      o_first_fault_ch    <= ch_d;
      o_first_fault_ts    <= ts_d;
    end
  end
endmodule

// File: tb/tb_intl_ext_monitor.sv
// Scoreboard bench: a cycle model built from the interlock rules pushes expected outputs
// each clock; a monitor pops and compares on the falling edge.

module tb_intl_ext_monitor;
  localparam int CH = 16, DW = 16, TW = 32, IW = 5;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic [CH-1:0] i_intl_ext = '0, i_intl_polarity = '1, i_intl_bypass = '0;
  logic [DW-1:0] i_deb_count = '0;
  logic          i_intl_clr = 1'b0;
  logic [CH-1:0] o_intl_raw, o_intl_state;
  logic          o_intl_any, o_first_fault_valid;
  logic [IW-1:0] o_first_fault_ch;
  logic [TW-1:0] o_first_fault_ts;

  always #5 i_clk = ~i_clk;

  intl_ext_monitor #(.CH_NUM(CH), .DEB_WIDTH(DW), .TS_WIDTH(TW), .CH_IDX_W(IW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_intl_ext(i_intl_ext), .i_intl_polarity(i_intl_polarity),
    .i_intl_bypass(i_intl_bypass), .i_deb_count(i_deb_count), .i_intl_clr(i_intl_clr),
    .o_intl_raw(o_intl_raw), .o_intl_state(o_intl_state), .o_intl_any(o_intl_any),
    .o_first_fault_valid(o_first_fault_valid), .o_first_fault_ch(o_first_fault_ch),
    .o_first_fault_ts(o_first_fault_ts)
  );

  typedef struct packed {
    logic [CH-1:0] raw;
    logic [CH-1:0] state;
    logic          any;
    logic          v;
    logic [IW-1:0] ch;
    logic [TW-1:0] ts;
  } obs_t;

  obs_t expq[$];
  int   checks = 0, passes = 0;

  // Reference model: inputs seen two clocks late, run-length debounce, latch/clear rules.
  logic [CH-1:0] h1, h2, m_raw, m_state, f, nraw, mmask, nstate, nset;
  int            run [CH];
  logic          m_clrp, m_v, ce, found;
  logic [IW-1:0] m_ch;
  logic [TW-1:0] m_ts, tsc;

  always @(posedge i_clk) begin
    obs_t e;
    if (!i_rst) begin
      h1 = '0; h2 = '0; m_raw = '0; m_state = '0; m_clrp = 1'b0;
      m_v = 1'b0; m_ch = '0; m_ts = '0; tsc = '0;
      for (int i = 0; i < CH; i++) run[i] = 0;
      e = '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        f[i]    = (h2[i] == i_intl_polarity[i]);
        nraw[i] = f[i] && (m_raw[i] || run[i] >= int'(i_deb_count));
        run[i]  = f[i] ? ((run[i] < 1000000) ? run[i] + 1 : run[i]) : 0;
      end
      mmask  = m_raw & ~i_intl_bypass;
      ce     = i_intl_clr && !m_clrp;
      nstate = ce ? mmask : (m_state | mmask);
      nset   = nstate & ~m_state;
      if (!m_v && nset != '0) begin
        found = 1'b0;
        for (int i = 0; i < CH; i++)
          if (nset[i] && !found) begin m_ch = IW'(i); found = 1'b1; end
        m_ts = tsc;
        m_v  = 1'b1;
      end else if (m_v && ce && nstate == '0) begin
        m_v = 1'b0; m_ch = '0; m_ts = '0;
      end
      tsc     = tsc + 1;
      h2      = h1;
      h1      = i_intl_ext;
      m_raw   = nraw;
      m_state = nstate;
      m_clrp  = i_intl_clr;
      e = '{raw: m_raw, state: m_state, any: |m_state, v: m_v, ch: m_ch, ts: m_ts};
    end
    expq.push_back(e);
  end

  // Monitor: clock-low events compare against the scoreboard; a reset fall while the
  // clock is high is the asynchronous-reset check (all outputs must already be 0).
  obs_t act, exp_v;
  always begin
    @(negedge i_clk or negedge i_rst);
    if (i_clk) begin
      #1;
      act = '{raw: o_intl_raw, state: o_intl_state, any: o_intl_any, v: o_first_fault_valid,
              ch: o_first_fault_ch, ts: o_first_fault_ts};
      checks++;
      if (act === obs_t'('0)) passes++;
      else $display("FAIL async_reset got raw=%h state=%h any=%b v=%b ch=%0d ts=%0d want all zero",
                    act.raw, act.state, act.any, act.v, act.ch, act.ts);
    end else if (expq.size() > 0) begin
      exp_v = expq.pop_front();
      if (!i_rst) exp_v = '0;
      act = '{raw: o_intl_raw, state: o_intl_state, any: o_intl_any, v: o_first_fault_valid,
              ch: o_first_fault_ch, ts: o_first_fault_ts};
      checks++;
      if (act === exp_v) passes++;
      else $display("FAIL cycle t=%0t got raw=%h state=%h any=%b v=%b ch=%0d ts=%0d want raw=%h state=%h any=%b v=%b ch=%0d ts=%0d",
                    $time, act.raw, act.state, act.any, act.v, act.ch, act.ts,
                    exp_v.raw, exp_v.state, exp_v.any, exp_v.v, exp_v.ch, exp_v.ts);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge i_clk);
    #1;
  endtask

  task automatic clr_pulse();
    i_intl_clr = 1'b1; wait_cyc(1); i_intl_clr = 1'b0; wait_cyc(3);
  endtask

  task automatic do_reset(input int n);
    @(posedge i_clk); #2; i_rst = 1'b0;
    wait_cyc(n);
    i_rst = 1'b1;
  endtask

  initial begin
    wait_cyc(3); i_rst = 1'b1; wait_cyc(3);
    // Zero debounce, single channel
    i_intl_ext[3] = 1'b1; wait_cyc(8); i_intl_ext = '0; wait_cyc(5); clr_pulse();
    // Debounce 10: short pulse rejected, long pulse accepted
    i_deb_count = 10;
    i_intl_ext[5] = 1'b1; wait_cyc(8);  i_intl_ext = '0; wait_cyc(15);
    i_intl_ext[5] = 1'b1; wait_cyc(20); i_intl_ext = '0; wait_cyc(6); clr_pulse();
    // Simultaneous faults, then a later one
    i_deb_count = 0;
    i_intl_ext[2] = 1'b1; i_intl_ext[7] = 1'b1; wait_cyc(6);
    i_intl_ext[9] = 1'b1; wait_cyc(6); i_intl_ext = '0; wait_cyc(4); clr_pulse();
    // Clear with fault active, then inactive, then clear held high
    i_intl_ext[4] = 1'b1; wait_cyc(6); clr_pulse();
    i_intl_ext = '0; wait_cyc(4); clr_pulse();
    i_intl_ext[6] = 1'b1; wait_cyc(6); i_intl_ext = '0; wait_cyc(4);
    i_intl_clr = 1'b1; wait_cyc(5);
    i_intl_ext[8] = 1'b1; wait_cyc(6); i_intl_ext = '0; wait_cyc(39);
    i_intl_clr = 1'b0; wait_cyc(2); clr_pulse();
    // Active-low channel and bypass
    i_intl_ext[0] = 1'b1; i_intl_polarity[0] = 1'b0; i_intl_bypass[1] = 1'b1; wait_cyc(5);
    i_intl_ext[0] = 1'b0; wait_cyc(6);
    i_intl_ext[1] = 1'b1; wait_cyc(6);
    i_intl_bypass[0] = 1'b1; wait_cyc(3);
    i_intl_ext[0] = 1'b1; i_intl_ext[1] = 1'b0; wait_cyc(5); clr_pulse();
    i_intl_polarity = '1; i_intl_bypass = '0; i_intl_ext = '0; wait_cyc(5); clr_pulse();
    // Reset mid-debounce, then while captured
    i_deb_count = 20;
    i_intl_ext[3] = 1'b1; wait_cyc(10); do_reset(2); wait_cyc(30);
    do_reset(2); i_intl_ext = '0; i_deb_count = 0; wait_cyc(3);
    i_intl_ext[11] = 1'b1; wait_cyc(8); i_intl_ext = '0; wait_cyc(4); clr_pulse();
    // Randomised traffic
    for (int blk = 0; blk < 6; blk++) begin
      i_deb_count = DW'($urandom_range(0, 4));
      for (int c = 0; c < 120; c++) begin
        for (int i = 0; i < CH; i++)
          if ($urandom_range(0, 9) == 0) i_intl_ext[i] = ~i_intl_ext[i];
        if ($urandom_range(0, 39) == 0) i_intl_polarity[$urandom_range(0, CH-1)] ^= 1'b1;
        if ($urandom_range(0, 29) == 0) i_intl_bypass[$urandom_range(0, CH-1)] ^= 1'b1;
        i_intl_clr = ($urandom_range(0, 14) == 0);
        if ($urandom_range(0, 199) == 0) do_reset($urandom_range(1, 3));
        else wait_cyc(1);
      end
      i_intl_ext = '0; i_intl_polarity = '1; i_intl_clr = 1'b0; wait_cyc(8); clr_pulse();
    end
    wait_cyc(3);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
